// File: rtl/y_divider_pkg.sv
// Shared CPU package: divider FSM encoding and fixed divider constants.
package y_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int unsigned DIV_ITER      = 32;
   localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/yArith.sv
// Add/subtract unit: z = a + b (ctrl=0) or a - b (ctrl=1); cout=1 on subtract means no borrow.
module yArith #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ctrl,
   output logic [WIDTH-1:0] z,
   output logic             cout
);

   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH:0]   w_sum;

   // Subtract as a + ~b + 1 so the carry out doubles as the no-borrow flag.
   assign w_b_eff     = b ^ {WIDTH{ctrl}};
   assign w_sum       = (WIDTH+1)'(a) + (WIDTH+1)'(w_b_eff) + (WIDTH+1)'(ctrl);
   assign z           = w_sum[WIDTH-1:0];
   assign cout        = w_sum[WIDTH];

endmodule

// File: rtl/y_divider.sv
// Multi-cycle restoring divider for the EX stage; one quotient bit per RUN cycle via yArith.
module y_divider
   import y_divider_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   generate
      if (WIDTH != 32) begin : g_width_check
         $error("y_divider: only WIDTH=32 is supported");
      end
   endgenerate

   div_state_t       r_state;
   div_state_t       w_next;

   logic [4:0]       r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dsr;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_q_neg;
   logic             r_r_neg;
   logic             r_dbz;

   logic             w_accept;
   logic             w_dsr_zero;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dsr_mag;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_cout;
   logic             w_take;

   assign w_accept   = start & ((r_state == IDLE) | (r_state == DONE));
   assign w_dsr_zero = (divisor == '0);
   assign w_dvd_mag  = (is_signed & dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
   assign w_dsr_mag  = (is_signed & divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

   // r_quo shifts the dividend out of its MSB while quotient bits shift in at the LSB.
   assign w_shift = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};

   yArith #(
      .WIDTH (WIDTH)
   ) u_trial_sub (
      .a    (w_shift),
      .b    (r_dsr),
      .ctrl (1'b1),
      .z    (w_diff),
      .cout (w_cout)
   );

   // r_rem[31] set means the shifted value has a 33rd bit, so it always exceeds the divisor.
   assign w_take = r_rem[WIDTH-1] | w_cout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = w_dsr_zero ? DONE : RUN;
         end
         RUN: begin
            if (r_cnt == 5'd0) w_next = FIX;
         end
         FIX: begin
            w_next = DONE;
         end
         DONE: begin
            if (w_accept) w_next = w_dsr_zero ? DONE : RUN;
            else          w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dsr       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_dbz       <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else if (w_accept) begin
         r_cnt   <= 5'(DIV_ITER - 1);
         r_rem   <= '0;
         r_quo   <= w_dvd_mag;
         r_dsr   <= w_dsr_mag;
         r_q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         r_r_neg <= is_signed & dividend[WIDTH-1];
         r_dbz   <= w_dsr_zero;
         if (w_dsr_zero) begin
            r_quotient  <= DIV_ZERO_QUOT;
            r_remainder <= dividend;
         end
      end else begin
         case (r_state)
            RUN: begin
               r_rem <= w_take ? w_diff : w_shift;
               r_quo <= {r_quo[WIDTH-2:0], w_take};
               r_cnt <= r_cnt - 5'd1;
            end
            FIX: begin
               r_quotient  <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
               r_remainder <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state == RUN) | (r_state == FIX);
   assign done        = (r_state == DONE);
   assign div_by_zero = (r_state == DONE) & r_dbz;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;

endmodule

// File: tb/tb_y_divider.sv
// Directed bench for y_divider: hand-computed results, latency and busy-cycle counts.
module tb_y_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   y_divider #(
      .WIDTH (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      start     = 1'b1;
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
   endtask

   // Called on the negedge where start was just raised; returns on the negedge where done is seen.
   task automatic wait_done(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r,
                            input logic exp_dbz, input int unsigned exp_lat,
                            input int unsigned exp_busy, input int unsigned glitch);
      int unsigned lat  = 0;
      int unsigned bcnt = 0;
      logic        seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == glitch) begin
            start     = 1'b1;
            is_signed = 1'b0;
            dividend  = 32'd9;
            divisor   = 32'd3;
         end else begin
            start = 1'b0;
         end
         if (done) seen = 1'b1;
         else      bcnt += 32'(busy);
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, bcnt, exp_busy);
      check({tag, "_quotient"}, quotient, exp_q);
      check({tag, "_remainder"}, remainder, exp_r);
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
   endtask

   task automatic op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_dbz);
      launch(sgn, a, b);
      wait_done(tag, exp_q, exp_r, exp_dbz, exp_dbz ? 1 : 34, exp_dbz ? 0 : 33, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_dbz_after"}, 32'(div_by_zero), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_q_hold"}, quotient, exp_q);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_quotient", quotient, 32'd0);
      check("reset_remainder", remainder, 32'd0);
      check("reset_dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
      op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
      op("s7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
      op("s_m100_m7",1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0);
      op("u_fff9_2", 1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0);
      op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
      op("u_max_big",1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0);
      op("dbz_u",    1'b0, 32'd12345,      32'd0,          32'hFFFF_FFFF,  32'd12345,      1'b1);
      op("dbz_s",    1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);
      op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);

      // start pulsed during RUN with different operands must not disturb the op in flight
      launch(1'b0, 32'd1000, 32'd10);
      wait_done("glitch", 32'd100, 32'd0, 1'b0, 34, 33, 5);
      @(negedge clk);
      check("glitch_idle", 32'(busy), 32'd0);

      // back-to-back: second start raised in the DONE cycle
      launch(1'b0, 32'd100, 32'd7);
      wait_done("b2b_first", 32'd14, 32'd2, 1'b0, 34, 33, 0);
      launch(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done("b2b_second", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 33, 0);
      @(negedge clk);

      // asynchronous reset in the middle of RUN
      launch(1'b0, 32'd100, 32'd7);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("mid_run_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      op("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
